dmem_arbiter: RTL and testbench

- Shares the single data_mem port between two requesters: port 0 is the core load/store path and port 1 is the debug/program-loader path.
- Port 0 has fixed priority. An anti-starvation counter guarantees that port 1 is served after MaxWait consecutive lost cycles.
- The block drives data_mem's r_en/wr_en/addr/wr_data/funct3 inputs combinationally from the granted port.
- It registers read data and returns it to the winning port one cycle after grant.

---
 rtl/dmem_arbiter_if.sv | 51 +++++
 rtl/dmem_arbiter.sv | 69 ++++++
 tb/tb_dmem_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle between the two data-memory requesters, the arbiter and the data_mem port.
// The slave modport is the arbiter's view; master is the environment driving requests and memory.
interface dmem_arbiter_if #(
    parameter int AddressWidth = 10
);
    logic                    p0_req_i;
    logic                    p0_we_i;
    logic [AddressWidth-1:0] p0_addr_i;
    logic [31:0]             p0_wdata_i;
    logic [2:0]              p0_funct3_i;
    logic                    p0_gnt_o;
    logic                    p0_rvalid_o;
    logic [31:0]             p0_rdata_o;

    logic                    p1_req_i;
    logic                    p1_we_i;
    logic [AddressWidth-1:0] p1_addr_i;
    logic [31:0]             p1_wdata_i;
    logic [2:0]              p1_funct3_i;
    logic                    p1_gnt_o;
    logic                    p1_rvalid_o;
    logic [31:0]             p1_rdata_o;

    logic                    mem_r_en_o;
    logic                    mem_wr_en_o;
    logic [AddressWidth-1:0] mem_addr_o;
    logic [31:0]             mem_wr_data_o;
    logic [2:0]              mem_funct3_o;
    logic [31:0]             mem_r_data_i;
    logic                    err_o;

    modport slave (
        input  p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i, p0_funct3_i,
        output p0_gnt_o, p0_rvalid_o, p0_rdata_o,
        input  p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i, p1_funct3_i,
        output p1_gnt_o, p1_rvalid_o, p1_rdata_o,
        output mem_r_en_o, mem_wr_en_o, mem_addr_o, mem_wr_data_o, mem_funct3_o,
        input  mem_r_data_i,
        output err_o
    );

    modport master (
        output p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i, p0_funct3_i,
        input  p0_gnt_o, p0_rvalid_o, p0_rdata_o,
        output p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i, p1_funct3_i,
        input  p1_gnt_o, p1_rvalid_o, p1_rdata_o,
        input  mem_r_en_o, mem_wr_en_o, mem_addr_o, mem_wr_data_o, mem_funct3_o,
        output mem_r_data_i,
        input  err_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port fixed-priority data_mem arbiter with anti-starvation for port 1; read data returns 1 cycle after grant.
// Backpressure: a requester holds its request until gnt; port 1 is forced through after MaxWait lost cycles.
module dmem_arbiter #(
    parameter int AddressWidth = 10,
    parameter int MaxWait      = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    dmem_arbiter_if.slave  bus
);
    localparam logic [3:0] MAX_WAIT = 4'(MaxWait);

    logic [3:0]              wait_cnt;
    logic [31:0]             rdata_q;
    logic                    gnt0;
    logic                    gnt1;
    logic                    any_gnt;
    logic                    sel_we;
    logic [AddressWidth-1:0] sel_addr;
    logic [31:0]             sel_wdata;
    logic [2:0]              sel_funct3;
    logic                    legal_st;

    always_comb begin
        gnt1 = ~rst_i & bus.p1_req_i & (~bus.p0_req_i | (wait_cnt == MAX_WAIT));
        gnt0 = ~rst_i & bus.p0_req_i & ~gnt1;
        any_gnt = gnt0 | gnt1;

        // With no grant the mux rests on port 0.
        sel_we     = gnt1 ? bus.p1_we_i     : bus.p0_we_i;
        sel_addr   = gnt1 ? bus.p1_addr_i   : bus.p0_addr_i;
        sel_wdata  = gnt1 ? bus.p1_wdata_i  : bus.p0_wdata_i;
        sel_funct3 = gnt1 ? bus.p1_funct3_i : bus.p0_funct3_i;

        legal_st = (sel_funct3 == 3'b000) | (sel_funct3 == 3'b001) | (sel_funct3 == 3'b010);
    end

    assign bus.p0_gnt_o      = gnt0;
    assign bus.p1_gnt_o      = gnt1;
    assign bus.mem_r_en_o    = any_gnt & ~sel_we;
    assign bus.mem_wr_en_o   = any_gnt & sel_we & legal_st;
    assign bus.mem_addr_o    = sel_addr;
    assign bus.mem_wr_data_o = sel_wdata;
    assign bus.mem_funct3_o  = sel_funct3;
    assign bus.p0_rdata_o    = rdata_q;
    assign bus.p1_rdata_o    = rdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt        <= 4'd0;
            rdata_q         <= 32'd0;
            bus.p0_rvalid_o <= 1'b0;
            bus.p1_rvalid_o <= 1'b0;
            bus.err_o       <= 1'b0;
        end else begin
            bus.p0_rvalid_o <= gnt0 & ~bus.p0_we_i;
            bus.p1_rvalid_o <= gnt1 & ~bus.p1_we_i;
            bus.err_o       <= any_gnt & sel_we & ~legal_st;
            if (bus.mem_r_en_o) begin
                rdata_q <= bus.mem_r_data_i;
            end
            if (gnt1) begin
                wait_cnt <= 4'd0;
            end else if (bus.p1_req_i && gnt0 && wait_cnt != MAX_WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random two-port traffic against a transaction-level model.
module tb_dmem_arbiter;
    localparam int AW = 10;
    localparam int MW = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    dmem_arbiter_if #(.AddressWidth(AW)) bus ();

    dmem_arbiter #(.AddressWidth(AW), .MaxWait(MW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ld(input logic [31:0] w, input logic [2:0] f3);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'd0, w[7:0]};
            3'b101:  return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st(input logic [31:0] old, input logic [31:0] d, input logic [2:0] f3);
        case (f3)
            3'b000:  return {old[31:8], d[7:0]};
            3'b001:  return {old[31:16], d[15:0]};
            default: return d;
        endcase
    endfunction

    // Environment data_mem: combinational read, write on posedge.
    logic [31:0] env_mem [16];
    always_comb bus.mem_r_data_i = ld(env_mem[bus.mem_addr_o[3:0]], bus.mem_funct3_o);
    always @(posedge clk) begin
        if (bus.mem_wr_en_o)
            env_mem[bus.mem_addr_o[3:0]] <= st(env_mem[bus.mem_addr_o[3:0]], bus.mem_wr_data_o, bus.mem_funct3_o);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    // Reference model state
    logic [31:0] ref_mem [16];
    int          losses;
    logic        e_rv0, e_rv1, e_err;
    logic [31:0] e_rdata;
    logic        m_g0, m_g1;

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [2:0]  f3;
    } rq_t;

    task automatic step(input logic r, input rq_t a, input rq_t b);
        logic        g0, g1, legal;
        rq_t         s;
        rst             = r;
        bus.p0_req_i    = a.req;  bus.p0_we_i = a.we;  bus.p0_addr_i = AW'(a.addr);
        bus.p0_wdata_i  = a.data; bus.p0_funct3_i = a.f3;
        bus.p1_req_i    = b.req;  bus.p1_we_i = b.we;  bus.p1_addr_i = AW'(b.addr);
        bus.p1_wdata_i  = b.data; bus.p1_funct3_i = b.f3;
        #2;
        // Outputs registered at the previous edge
        chk("p0_rvalid", 32'(bus.p0_rvalid_o), 32'(e_rv0));
        chk("p1_rvalid", 32'(bus.p1_rvalid_o), 32'(e_rv1));
        chk("err", 32'(bus.err_o), 32'(e_err));
        chk("p0_rdata", bus.p0_rdata_o, e_rdata);
        chk("p1_rdata", bus.p1_rdata_o, e_rdata);
        // Arbitration decision for this cycle
        g1 = !r && b.req && (!a.req || losses >= MW);
        g0 = !r && a.req && !g1;
        s  = g1 ? b : a;
        legal = (s.f3 <= 3'd2);
        chk("p0_gnt", 32'(bus.p0_gnt_o), 32'(g0));
        chk("p1_gnt", 32'(bus.p1_gnt_o), 32'(g1));
        chk("mem_r_en", 32'(bus.mem_r_en_o), 32'((g0 || g1) && !s.we));
        chk("mem_wr_en", 32'(bus.mem_wr_en_o), 32'((g0 || g1) && s.we && legal));
        chk("mem_addr", 32'(bus.mem_addr_o), 32'(s.addr));
        chk("mem_wr_data", bus.mem_wr_data_o, s.data);
        chk("mem_funct3", 32'(bus.mem_funct3_o), 32'(s.f3));
        m_g0 = g0;
        m_g1 = g1;
        if (r) begin
            e_rv0 = 0; e_rv1 = 0; e_err = 0; e_rdata = 0; losses = 0;
        end else begin
            e_rv0 = g0 && !a.we;
            e_rv1 = g1 && !b.we;
            e_err = (g0 || g1) && s.we && !legal;
            if ((g0 || g1) && !s.we) e_rdata = ld(ref_mem[s.addr], s.f3);
            if ((g0 || g1) && s.we && legal) ref_mem[s.addr] = st(ref_mem[s.addr], s.data, s.f3);
            if (g1) losses = 0;
            else if (b.req && g0) losses = (losses + 1 > MW) ? MW : losses + 1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic rq_t mk(input logic req, input logic we, input logic [3:0] addr,
                               input logic [31:0] data, input logic [2:0] f3);
        rq_t t;
        t.req = req; t.we = we; t.addr = addr; t.data = data; t.f3 = f3;
        return t;
    endfunction

    rq_t idle, pa, pb;
    int  p1_wins;

    initial begin
        checks = 0; failures = 0;
        losses = 0; e_rv0 = 0; e_rv1 = 0; e_err = 0; e_rdata = 0;
        for (int i = 0; i < 16; i++) begin
            env_mem[i] = 32'(i) * 32'h11;
            ref_mem[i] = 32'(i) * 32'h11;
        end
        idle = mk(0, 0, 0, 0, 0);
        rst = 1;
        bus.p0_req_i = 0; bus.p0_we_i = 0; bus.p0_addr_i = 0; bus.p0_wdata_i = 0; bus.p0_funct3_i = 0;
        bus.p1_req_i = 0; bus.p1_we_i = 0; bus.p1_addr_i = 0; bus.p1_wdata_i = 0; bus.p1_funct3_i = 0;
        @(posedge clk); #1;
        step(1, idle, idle);
        step(1, mk(1, 1, 4'd9, 32'hCAFE0000, 3'b010), idle);
        chk("rst_rdata_zero", bus.p0_rdata_o, 32'd0);

        // Single-port store then load, port 1 sign-extending byte load
        step(0, mk(1, 1, 4'd5, 32'hDEADBEEF, 3'b010), idle);
        step(0, mk(1, 0, 4'd5, 32'h0, 3'b010), idle);
        step(0, idle, idle);
        chk("lw5", bus.p0_rdata_o, 32'hDEADBEEF);
        step(0, idle, mk(1, 0, 4'd5, 32'h0, 3'b000));
        step(0, idle, idle);
        chk("lb5", bus.p1_rdata_o, 32'hFFFFFFEF);

        // Illegal store is consumed without writing
        step(0, mk(1, 1, 4'd7, 32'h12345678, 3'b011), idle);
        step(0, idle, idle);
        step(0, mk(1, 0, 4'd7, 32'h0, 3'b010), idle);
        step(0, idle, idle);
        chk("lw7_old", bus.p0_rdata_o, 32'h77);

        // Alternating back-to-back reads
        step(0, mk(1, 0, 4'd1, 32'h0, 3'b010), idle);
        step(0, idle, mk(1, 0, 4'd2, 32'h0, 3'b010));
        step(0, idle, idle);
        chk("lw2_p1", bus.p1_rdata_o, 32'h22);

        // Continuous contention: expect 4:1
        p1_wins = 0;
        for (int i = 0; i < 15; i++) begin
            step(0, mk(1, 0, 4'd3, 32'h0, 3'b010), mk(1, 0, 4'd4, 32'h0, 3'b010));
            if (m_g1) p1_wins++;
        end
        chk("contention_p1_wins", 32'(p1_wins), 32'd3);
        step(0, idle, idle);

        // Reset right after a read grant, with a write requested during reset
        step(0, mk(1, 0, 4'd3, 32'h0, 3'b010), idle);
        step(1, mk(1, 1, 4'd3, 32'hBAD0BAD0, 3'b010), mk(1, 1, 4'd3, 32'hBAD1BAD1, 3'b010));
        chk("mid_rst_rvalid", 32'(bus.p0_rvalid_o), 32'd0);
        chk("mid_rst_rdata", bus.p0_rdata_o, 32'd0);
        step(0, mk(1, 0, 4'd3, 32'h0, 3'b010), idle);
        step(0, idle, idle);
        chk("lw3_after_rst", bus.p0_rdata_o, 32'h33);

        // Random traffic; each requester holds its request until granted
        pa = idle; pb = idle;
        for (int i = 0; i < 400; i++) begin
            logic r;
            if (!pa.req && $urandom_range(0, 99) < 70)
                pa = mk(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 3'($urandom_range(0, 7)));
            if (!pb.req && $urandom_range(0, 99) < 50)
                pb = mk(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 3'($urandom_range(0, 7)));
            r = ($urandom_range(0, 59) == 0);
            step(r, pa, pb);
            if (m_g0) pa = idle;
            if (m_g1) pb = idle;
        end
        step(0, idle, idle);
        for (int i = 0; i < 16; i++) chk("final_mem", env_mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
